mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_resp_pipe.sv | 40 ++++
 rtl/mem_arbiter.sv | 88 ++++++++
 tb/tb_mem_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding, response record and latency limits for mem_arbiter
//   owner_e      : which requester an accepted access belongs to (OWN_I / OWN_D)
//   resp_t       : one response-pipeline stage {valid, owner, we}
//   MEM_LAT_MIN/MAX : legal memory read latency range
//   clamp_lat()  : folds an out-of-range latency back into the legal range
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   we;
    } resp_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

    function automatic int clamp_lat(input int lat);
        return (lat < MEM_LAT_MIN) ? MEM_LAT_MIN : (lat > MEM_LAT_MAX) ? MEM_LAT_MAX : lat;
    endfunction

endpackage

// File: rtl/mem_arb_resp_pipe.sv
// mem_arb_resp_pipe: MEM_LAT-deep shift register tracking accepted accesses until their data returns
//   clk      in  : rising-edge clock
//   reset    in  : asynchronous active-low reset, flushes every stage
//   i_push   in  : an access is accepted on this edge
//   i_owner  in  : requester that owns the accepted access
//   i_we     in  : accepted access is a write (response carries no data)
//   o_valid  out : a response is due this cycle
//   o_owner  out : owner of the due response
//   o_we     out : due response is a write acknowledge
module mem_arb_resp_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_push,
    input  owner_e i_owner,
    input  logic   i_we,
    output logic   o_valid,
    output owner_e o_owner,
    output logic   o_we
);

    resp_t r_pipe [MEM_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{valid: i_push, owner: i_owner, we: i_we};
            for (int i = 1; i < MEM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_valid = r_pipe[MEM_LAT-1].valid;
    assign o_owner = r_pipe[MEM_LAT-1].owner;
    assign o_we    = r_pipe[MEM_LAT-1].we;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data load-store) arbiter in front of one single-port synchronous memory
//   clk, reset (async, active-low)
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata                       : read-only instruction port
//   d_req/d_we/d_addr/d_wdata/d_wstrb -> d_gnt/d_rvalid/d_rdata  : data port; writes get a data-less acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata/mem_wstrb, mem_rdata        : memory side, read data returns MEM_LAT cycles after access
//   Parameters: ADDR_W, DATA_W, MEM_LAT (1..4)
//   Macro MEM_ARBITER_RR_EN: round-robin on conflict; otherwise the data port always wins.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LAT = clamp_lat(MEM_LAT);

    owner_e r_last_owner;
    logic   w_d_win;
    logic   w_rvalid;
    owner_e w_rowner;
    logic   w_rwe;

`ifdef MEM_ARBITER_RR_EN
    // On conflict the data port wins only if the instruction port was served last.
    assign w_d_win = d_req & (~i_req | (r_last_owner == OWN_I));
`else
    assign w_d_win = d_req;
`endif

    // Grants are gated by reset so nothing is issued while it is held.
    always_comb begin
        d_gnt     = reset & w_d_win;
        i_gnt     = reset & i_req & ~w_d_win;
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = d_gnt ? d_addr : i_gnt ? i_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        mem_wstrb = d_gnt ? d_wstrb : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_last_owner <= OWN_I;
        else if (mem_en) r_last_owner <= d_gnt ? OWN_D : OWN_I;
    end

    mem_arb_resp_pipe #(.MEM_LAT(LAT)) u_resp_pipe (
        .clk     (clk),
        .reset   (reset),
        .i_push  (mem_en),
        .i_owner (d_gnt ? OWN_D : OWN_I),
        .i_we    (mem_we),
        .o_valid (w_rvalid),
        .o_owner (w_rowner),
        .o_we    (w_rwe)
    );

    // Write acknowledges carry no data, so d_rdata stays 0 for them.
    always_comb begin
        i_rvalid = w_rvalid & (w_rowner == OWN_I);
        d_rvalid = w_rvalid & (w_rowner == OWN_D);
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = (d_rvalid & ~w_rwe) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench driving mem_arbiter instances with MEM_LAT = 1, 2, 3 in parallel
module tb_mem_arbiter;

    localparam logic [31:0] K = 32'hDEADBFEF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;

    logic        i_gnt [1:3], i_rvalid [1:3], d_gnt [1:3], d_rvalid [1:3], mem_en [1:3], mem_we [1:3];
    logic [31:0] i_rdata [1:3], d_rdata [1:3], mem_addr [1:3], mem_wdata [1:3], mem_rdata [1:3];
    logic [3:0]  mem_wstrb [1:3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        logic [31:0] r_dly [0:g-1];
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .i_req     (i_req),
            .i_addr    (i_addr),
            .i_gnt     (i_gnt[g]),
            .i_rvalid  (i_rvalid[g]),
            .i_rdata   (i_rdata[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_wstrb   (d_wstrb),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_rdata (mem_rdata[g])
        );
        // Memory model: returns addr ^ K exactly g cycles after the access.
        always @(posedge clk) begin
            r_dly[0] <= mem_addr[g];
            for (int k = 1; k < g; k++) r_dly[k] <= r_dly[k-1];
        end
        assign mem_rdata[g] = r_dly[g-1] ^ K;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr();
        i_req = 0; d_req = 0; d_we = 0; i_addr = '0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    endtask

    task automatic idle(input int n);
        clr();
        repeat (n) @(negedge clk);
    endtask

`ifdef MEM_ARBITER_RR_EN
    localparam logic [3:0] EXP_D = 4'b0101;
`else
    localparam logic [3:0] EXP_D = 4'b1111;
`endif

    initial begin
        // Reset state with requests already pending.
        i_req = 1; d_req = 1; i_addr = 32'h100; d_addr = 32'h200;
        @(negedge clk); #2;
        for (int u = 1; u <= 3; u++) begin
            check("rst_i_gnt", {31'b0, i_gnt[u]}, 0);
            check("rst_d_gnt", {31'b0, d_gnt[u]}, 0);
            check("rst_mem_en", {31'b0, mem_en[u]}, 0);
            check("rst_mem_addr", mem_addr[u], 0);
            check("rst_rvalid", {30'b0, i_rvalid[u], d_rvalid[u]}, 0);
        end
        clr();
        @(negedge clk); reset = 1;
        @(negedge clk);

        // Single instruction read.
        i_req = 1; i_addr = 32'h100; #2;
        check("i_gnt", {31'b0, i_gnt[1]}, 1);
        check("i_d_gnt", {31'b0, d_gnt[1]}, 0);
        check("i_mem_en", {31'b0, mem_en[1]}, 1);
        check("i_mem_addr", mem_addr[1], 32'h100);
        @(negedge clk); clr(); #2;
        check("l1_i_rvalid", {31'b0, i_rvalid[1]}, 1);
        check("l1_i_rdata", i_rdata[1], 32'hDEADBEEF);
        check("l1_d_rvalid", {31'b0, d_rvalid[1]}, 0);
        check("l2_i_rvalid_early", {31'b0, i_rvalid[2]}, 0);
        @(negedge clk); #2;
        check("l1_i_rvalid_one", {31'b0, i_rvalid[1]}, 0);
        check("l1_i_rdata_zero", i_rdata[1], 0);
        check("l2_i_rvalid", {31'b0, i_rvalid[2]}, 1);
        check("l2_i_rdata", i_rdata[2], 32'hDEADBEEF);
        @(negedge clk); #2;
        check("l3_i_rvalid", {31'b0, i_rvalid[3]}, 1);
        idle(2);

        // Instruction grant must not leak the data port's write controls.
        i_req = 1; i_addr = 32'h40; d_we = 1; d_wstrb = 4'hF; d_wdata = 32'hFFFF; #2;
        check("ig_gnt", {31'b0, i_gnt[1]}, 1);
        check("ig_mem_we", {31'b0, mem_we[1]}, 0);
        check("ig_mem_wstrb", {28'b0, mem_wstrb[1]}, 0);
        check("ig_mem_wdata", mem_wdata[1], 0);
        idle(4);

        // Data write with acknowledge.
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'h12345678; d_wstrb = 4'hF; #2;
        check("w_d_gnt", {31'b0, d_gnt[1]}, 1);
        check("w_mem_we", {31'b0, mem_we[1]}, 1);
        check("w_mem_wstrb", {28'b0, mem_wstrb[1]}, 32'hF);
        check("w_mem_wdata", mem_wdata[1], 32'h12345678);
        check("w_mem_addr", mem_addr[1], 32'h2000);
        for (int u = 1; u <= 3; u++) begin
            @(negedge clk); clr(); #2;
            check("w_d_rvalid", {31'b0, d_rvalid[u]}, 1);
            check("w_d_rdata", d_rdata[u], 0);
            check("w_i_rvalid", {31'b0, i_rvalid[u]}, 0);
        end
        idle(3);

        // Reset one cycle after a grant: the access must vanish.
        i_req = 1; i_addr = 32'h300; #2;
        check("rf_gnt", {31'b0, i_gnt[2]}, 1);
        @(negedge clk); clr(); reset = 0; #2;
        for (int u = 1; u <= 3; u++) begin
            check("rf_rvalid", {30'b0, i_rvalid[u], d_rvalid[u]}, 0);
            check("rf_mem_en", {31'b0, mem_en[u]}, 0);
            check("rf_rdata", i_rdata[u] | d_rdata[u], 0);
        end
        @(negedge clk); #2;
        check("rf_l2_rvalid", {30'b0, i_rvalid[2], d_rvalid[2]}, 0);

        // Release reset straight into a 4-cycle conflict.
        @(negedge clk);
        reset = 1; i_req = 1; d_req = 1; i_addr = 32'h500; d_addr = 32'h600;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            check($sformatf("cf_d_gnt%0d", k), {31'b0, d_gnt[1]}, {31'b0, EXP_D[k]});
            check($sformatf("cf_i_gnt%0d", k), {31'b0, i_gnt[1]}, {31'b0, ~EXP_D[k]});
            check($sformatf("cf_mem_addr%0d", k), mem_addr[1], EXP_D[k] ? 32'h600 : 32'h500);
            if (k > 0) begin
                check($sformatf("cf_d_rdata%0d", k), d_rdata[1], EXP_D[k-1] ? 32'hDEADB9EF : 0);
                check($sformatf("cf_i_rdata%0d", k), i_rdata[1], EXP_D[k-1] ? 0 : 32'hDEADBAEF);
            end
            if (k == 1 || k == 2) check("rf_l3_no_rvalid", {31'b0, i_rvalid[3]}, 0);
        end
        @(negedge clk); clr(); #2;
        check("cf_d_rvalid3", {31'b0, d_rvalid[1]}, {31'b0, EXP_D[3]});
        check("cf_i_rvalid3", {31'b0, i_rvalid[1]}, {31'b0, ~EXP_D[3]});
        idle(5);

        // Back-to-back I, D, I reads through MEM_LAT=3.
        i_req = 1; i_addr = 32'h700; #2;
        check("bb_i_gnt0", {31'b0, i_gnt[3]}, 1);
        @(negedge clk); clr(); d_req = 1; d_addr = 32'h800; #2;
        check("bb_d_gnt1", {31'b0, d_gnt[3]}, 1);
        @(negedge clk); clr(); i_req = 1; i_addr = 32'h900; #2;
        check("bb_i_gnt2", {31'b0, i_gnt[3]}, 1);
        check("bb_none2", {30'b0, i_rvalid[3], d_rvalid[3]}, 0);
        @(negedge clk); clr(); #2;
        check("bb_rv3", {30'b0, i_rvalid[3], d_rvalid[3]}, 2);
        check("bb_i_rdata3", i_rdata[3], 32'hDEADB8EF);
        @(negedge clk); #2;
        check("bb_rv4", {30'b0, i_rvalid[3], d_rvalid[3]}, 1);
        check("bb_d_rdata4", d_rdata[3], 32'hDEADB7EF);
        @(negedge clk); #2;
        check("bb_rv5", {30'b0, i_rvalid[3], d_rvalid[3]}, 2);
        check("bb_i_rdata5", i_rdata[3], 32'hDEADB6EF);
        @(negedge clk); #2;
        check("bb_rv6", {30'b0, i_rvalid[3], d_rvalid[3]}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
